mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory-access stage of the MIPS datapath. Sits directly upstream of the word-addressed data memory and drives its addr/din/rw inputs. Consumes the memory's registered read output.
- Converts byte-addressed load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) into word accesses. Sub-word stores are done as read-modify-write; load data is formatted with sign or zero extension.
- Uses a valid/ready handshake on both sides of the execute/writeback path.

Parameters:
- ADDR_WIDTH, 10, word-address width of the data memory. Byte address space is ADDR_WIDTH+2 bits.

Ports:
- clk  in  1  clock. Everything is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  0 = load, 1 = store.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response valid. Held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  formatted load data. 0 for stores and errors.
- rsp_err  out  1  misaligned, reserved size, or out-of-range (see option).
- mem_addr  out  ADDR_WIDTH  word address to data memory.
- mem_din  out  32  write data to data memory.
- mem_rw  out  1  0 = read, 1 = write. The memory acts on the rising edge.
- mem_rdata  in  32  registered memory read data. Valid the cycle after a rw=0 edge.

Behaviour:
- Reset values:
  - state IDLE, req_ready=1
  - rsp_valid=0, rsp_data=0, rsp_err=0
  - mem_addr=0, mem_din=0, mem_rw=0
- mem_rw must be 0 whenever rst_n is low, with no glitch. Asserting reset mid-operation aborts the access; a pending sub-word write is never issued.
- Byte order is big-endian. addr[1:0]=0 selects bits [31:24]; half at addr[1]=0 selects [31:16].
- On accept, latch all request fields. word address = req_addr[ADDR_WIDTH+1:2].
- Error cases, which perform no memory access (mem_rw stays 0):
  - req_size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
- States:
  - IDLE: req_ready=1. On accept: if error, go to RESP with rsp_err=1; else go to ISSUE.
  - ISSUE: mem_addr driven.
    - Word store: mem_rw=1, mem_din=wdata; next RESP.
    - Otherwise: mem_rw=0 (read); next CAPTURE.
  - CAPTURE: mem_rw=0, address held.
    - Load: register formatted data into rsp_data; next RESP.
    - Sub-word store: register merged word (selected lanes replaced, others kept from mem_rdata); next WRITE.
  - WRITE: mem_rw=1, mem_din=merged word; next RESP.
  - RESP: rsp_valid=1, req_ready=0. On rsp_ready go to IDLE and clear rsp_valid.
- req_ready is 0 outside IDLE. One outstanding request at a time.
- Latency from the accept edge to rsp_valid high:
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
  - error: 1 cycle
- Back-to-back: the next request can be accepted on the cycle after rsp handshake completes, since IDLE is entered then.
- rsp_ready asserted early (before RESP) has no effect.
- mem_addr and mem_din hold their last values in IDLE and RESP. mem_rw=0 in every state except the write cycles above.

Optional Feature:
- Macro: MEM_ACCESS_RANGE_CHECK_EN.
  - Defined: a request with any of req_addr[31:ADDR_WIDTH+2] nonzero is an error. It gets rsp_err=1, no memory access, 1-cycle latency.
  - Undefined: the upper address bits are ignored and addresses alias modulo 2^(ADDR_WIDTH+2).

Test Plan:
- Preload word0=0x000007D1. LB addr 3, signed -> rsp_data=0xFFFFFFD1, rsp_err=0, rsp_valid 3 cycles after accept. LBU addr 3 -> 0x000000D1.
- Preload word1=0x00000FA1. SH addr 4, wdata=0x0000BEEF -> word1=0xBEEF0FA1, one write pulse only, rsp_valid 4 cycles after accept. LW addr 4 -> 0xBEEF0FA1.
- SW addr 8, wdata=0x12345678 -> mem_rw=1 for exactly one cycle with mem_addr=2, rsp_valid 2 cycles after. LH addr 10 -> 0x00005678.
- LW addr 6 and SH addr 5 -> rsp_err=1 after 1 cycle, mem_rw never 1, rsp_data=0. With MEM_ACCESS_RANGE_CHECK_EN: LW 0x00001000 -> rsp_err=1. Without it, the same request reads word0.
- SB addr 1 wdata=0xAA with reset pulled low in CAPTURE -> mem_rw stays 0 and the addressed word is unchanged. After release, outputs are at reset values and req_ready=1.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0. On release, a new request is accepted the next cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front end for a word-addressed, registered-read data memory.
// Define MEM_ACCESS_RANGE_CHECK_EN to flag requests whose address lies beyond the memory as errors.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic                  mem_rw,
  input  logic [31:0]           mem_rdata
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WRITE, RESP} state_t;
  state_t      state;
  logic        we, uns, err, range_err;
  logic [1:0]  size, off;
  logic [15:0] wdata;
  logic [4:0]  bsh, hsh;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] lane_mask, lane_data, ld_data;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
  assign range_err = |req_addr[31:ADDR_WIDTH+2];
`else
  logic unused_hi;
  assign unused_hi = ^req_addr[31:ADDR_WIDTH+2];
  assign range_err = 1'b0;
`endif
  // Big-endian lanes: byte offset 0 is the most significant byte.
  always_comb begin
    err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
          (req_size == 2'b10 && req_addr[1:0] != 2'b00) || range_err;
    bsh = {~off, 3'b000};
    hsh = {~off[1], 4'b0000};
    bsel = 8'(mem_rdata >> bsh);
    hsel = 16'(mem_rdata >> hsh);
    lane_mask = size == 2'b00 ? 32'h0000_00FF << bsh : 32'h0000_FFFF << hsh;
    lane_data = size == 2'b00 ? {24'b0, wdata[7:0]} << bsh : {16'b0, wdata} << hsh;
    ld_data = size == 2'b10 ? mem_rdata :
              size == 2'b00 ? {{24{~uns & bsel[7]}}, bsel} : {{16{~uns & hsel[15]}}, hsel};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_rw    <= 1'b0;
      we        <= 1'b0;
      uns       <= 1'b0;
      size      <= '0;
      off       <= '0;
      wdata     <= '0;
    end else begin
      mem_rw <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we        <= req_we;
          uns       <= req_unsigned;
          size      <= req_size;
          off       <= req_addr[1:0];
          wdata     <= req_wdata[15:0];
          rsp_data  <= '0;
          rsp_err   <= err;
          req_ready <= 1'b0;
          if (err) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            mem_addr <= req_addr[ADDR_WIDTH+1:2];
            state    <= ISSUE;
            if (req_we && req_size == 2'b10) begin
              mem_rw  <= 1'b1;
              mem_din <= req_wdata;
            end
          end
        end
        ISSUE: if (we && size == 2'b10) begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else state <= CAPTURE;
        CAPTURE: if (!we) begin
          rsp_data  <= ld_data;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else begin
          mem_din <= (mem_rdata & ~lane_mask) | lane_data;
          mem_rw  <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
